// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams a byte image into instruction memory
// from BASE_ADDR while stalling the core, then reports done/err and an additive checksum.
module imem_loader #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = 32'hBFC00000,
    parameter int unsigned MAX_BYTES     = 4096,
    parameter int unsigned LEN_WIDTH     = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     len,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_stall,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [7:0]               checksum
);

    localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_BYTES);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     remain_q, remain_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     err_q, err_d;
    logic [7:0]               checksum_q, checksum_d;
    logic                     len_ok;

    assign len_ok = (len != '0) && (len <= MaxLen) && (len[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        checksum_d  = checksum_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        state_d    = StLoad;
                        remain_d   = len;
                        addr_d     = BASE_ADDR;
                        checksum_d = 8'h00;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                // Abort wins over a byte offered in the same cycle; that byte is dropped.
                if (abort) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    remain_d    = remain_q - LEN_WIDTH'(1);
                    checksum_d  = checksum_q + 8'(in_data);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= BASE_ADDR;
            remain_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            checksum_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            checksum_q  <= checksum_d;
        end
    end

    // Handshake and status are pure state decodes so no input reaches an output.
    assign in_ready  = (state_q == StLoad);
    assign cpu_stall = (state_q == StLoad) || (state_q == StDrain);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes, checksum and status
// come from a simple image/queue model of the load protocol.
module tb_imem_loader;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXB = 4096;
    localparam int unsigned LW   = 13;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, mem_we, cpu_stall, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    checksum;
    logic [4:0]    flags;

    imem_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BASE_ADDR    (BASE),
        .MAX_BYTES    (MAXB),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    assign flags = {in_ready, cpu_stall, busy, done, err};

    int total = 0;
    int bad   = 0;
    int n_we = 0, n_done = 0, n_err = 0;
    logic [7:0] model_sum = 8'h00;
    logic [7:0] img[$];
    bit         vpat[$];

    task automatic tick;
        @(posedge clk);
        #1;
        if (mem_we) n_we++;
        if (done) n_done++;
        if (err) n_err++;
    endtask

    // mode 0: in_valid always high, 1: random gaps, 2: vpat then high.
    // cut_at >= 0: on offering byte cut_at, assert abort (or rst when cut_rst).
    task automatic load(input int n, input int mode, input int cut_at, input bit cut_rst);
        int acc = 0;
        int pi = 0;
        int guard = 0;
        bit v;
        logic [7:0] d;
        logic [AW-1:0] exp_addr;
        start = 1'b1;
        len = LW'(n);
        tick;
        start = 1'b0;
        model_sum = 8'h00;
        total++;
        if (flags !== 5'b11100) begin
            bad++;
            $display("FAIL load_enter flags got=%b want=11100", flags);
        end
        while (acc < n && guard < 20000) begin
            guard++;
            case (mode)
                0: v = 1'b1;
                1: v = ($urandom_range(0, 3) != 0);
                default: v = (pi < vpat.size()) ? vpat[pi] : 1'b1;
            endcase
            pi++;
            d = img[acc];
            in_valid = v;
            in_data = v ? d : 8'($urandom);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready got=%b want=1 at byte %0d", in_ready, acc);
            end
            if (v && acc == cut_at) begin
                if (cut_rst) rst = 1'b1;
                else abort = 1'b1;
                tick;
                in_valid = 1'b0;
                abort = 1'b0;
                if (cut_rst) begin
                    rst = 1'b0;
                    model_sum = 8'h00;
                    total++;
                    if ({flags, mem_we, mem_addr, mem_wdata, checksum} !== {6'b0, BASE, 16'h0}) begin
                        bad++;
                        $display("FAIL midload_reset got flags=%b we=%b addr=%h data=%h sum=%h want 0/0/%h/00/00",
                                 flags, mem_we, mem_addr, mem_wdata, checksum, BASE);
                    end
                end else begin
                    total++;
                    if ({flags, mem_we, checksum} !== {5'b00001, 1'b0, model_sum}) begin
                        bad++;
                        $display("FAIL abort_cycle got flags=%b we=%b sum=%h want flags=00001 we=0 sum=%h",
                                 flags, mem_we, checksum, model_sum);
                    end
                end
                tick;
                total++;
                if (flags !== 5'b00000) begin
                    bad++;
                    $display("FAIL cut_settle flags got=%b want=00000", flags);
                end
                return;
            end
            tick;
            in_valid = 1'b0;
            if (v) begin
                model_sum = model_sum + d;
                exp_addr = BASE + AW'(acc);
                acc++;
                total++;
                if ({mem_we, mem_addr, mem_wdata, checksum} !== {1'b1, exp_addr, d, model_sum}) begin
                    bad++;
                    $display("FAIL load_write got we=%b addr=%h data=%h sum=%h want we=1 addr=%h data=%h sum=%h",
                             mem_we, mem_addr, mem_wdata, checksum, exp_addr, d, model_sum);
                end
            end else begin
                total++;
                if (mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL load_gap we got=%b want=0", mem_we);
                end
            end
        end
        total++;
        if (guard >= 20000) begin
            bad++;
            $display("FAIL load_timeout accepted=%0d want=%0d", acc, n);
        end
        total++;
        if (flags !== 5'b01100) begin
            bad++;
            $display("FAIL drain flags got=%b want=01100", flags);
        end
        tick;
        total++;
        if ({flags, mem_we} !== 6'b001100) begin
            bad++;
            $display("FAIL done_cycle got flags=%b we=%b want flags=00110 we=0", flags, mem_we);
        end
        tick;
        total++;
        if ({flags, checksum} !== {5'b00000, model_sum}) begin
            bad++;
            $display("FAIL load_end got flags=%b sum=%h want flags=00000 sum=%h", flags, checksum, model_sum);
        end
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    task automatic test_reset;
        int we0, err0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        total++;
        if ({flags, mem_we, mem_addr, mem_wdata, checksum} !== {6'b0, BASE, 16'h0}) begin
            bad++;
            $display("FAIL reset_values got flags=%b we=%b addr=%h data=%h sum=%h want 0/0/%h/00/00",
                     flags, mem_we, mem_addr, mem_wdata, checksum, BASE);
        end
        we0 = n_we;
        err0 = n_err;
        for (int i = 0; i < 10; i++) begin
            abort = $urandom_range(0, 1) != 0;
            tick;
        end
        abort = 1'b0;
        total++;
        if ((n_we - we0) != 0 || (n_err - err0) != 0) begin
            bad++;
            $display("FAIL idle_quiet got writes=%0d errs=%0d want 0/0", n_we - we0, n_err - err0);
        end
    endtask

    task automatic test_basic;
        int we0 = n_we;
        int dn0 = n_done;
        img.delete();
        for (int i = 1; i <= 8; i++) img.push_back(8'(i));
        load(8, 0, -1, 1'b0);
        total++;
        if (checksum !== 8'h24 || (n_we - we0) != 8 || (n_done - dn0) != 1) begin
            bad++;
            $display("FAIL basic_totals got sum=%h writes=%0d dones=%0d want 24/8/1",
                     checksum, n_we - we0, n_done - dn0);
        end
    endtask

    task automatic test_backpressure;
        int we0 = n_we;
        fill_random(4);
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        load(4, 2, -1, 1'b0);
        total++;
        if ((n_we - we0) != 4) begin
            bad++;
            $display("FAIL backpressure_writes got=%0d want=4", n_we - we0);
        end
    endtask

    task automatic test_invalid_len;
        logic [LW-1:0] lens[$];
        logic [LW-1:0] r;
        lens = '{13'd0, 13'd6, 13'd4100};
        do r = LW'($urandom); while (r != 0 && r <= MAXB && r % 4 == 0);
        lens.push_back(r);
        foreach (lens[i]) begin
            start = 1'b1;
            len = lens[i];
            tick;
            start = 1'b0;
            total++;
            if ({flags, mem_we} !== 6'b000010) begin
                bad++;
                $display("FAIL bad_len_err len=%0d got flags=%b we=%b want flags=00001 we=0",
                         lens[i], flags, mem_we);
            end
            tick;
            total++;
            if ({flags, mem_we, checksum} !== {6'b0, model_sum}) begin
                bad++;
                $display("FAIL bad_len_after len=%0d got flags=%b we=%b sum=%h want 0/0/%h",
                         lens[i], flags, mem_we, checksum, model_sum);
            end
        end
    endtask

    task automatic test_abort;
        int we0 = n_we;
        int dn0 = n_done;
        int er0 = n_err;
        fill_random(16);
        load(16, 0, 4, 1'b0);
        tick;
        total++;
        if ((n_we - we0) != 4 || (n_done - dn0) != 0 || (n_err - er0) != 1) begin
            bad++;
            $display("FAIL abort_totals got writes=%0d dones=%0d errs=%0d want 4/0/1",
                     n_we - we0, n_done - dn0, n_err - er0);
        end
    endtask

    task automatic test_reset_midload;
        int we0;
        fill_random(8);
        load(8, 0, 3, 1'b1);
        we0 = n_we;
        fill_random(4);
        load(4, 0, -1, 1'b0);
        total++;
        if ((n_we - we0) != 4) begin
            bad++;
            $display("FAIL reload_writes got=%0d want=4", n_we - we0);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++) begin
            int n = 4 * $urandom_range(1, 16);
            fill_random(n);
            load(n, 1, -1, 1'b0);
        end
    endtask

    task automatic test_max_len;
        int we0 = n_we;
        fill_random(MAXB);
        load(MAXB, 0, -1, 1'b0);
        total++;
        if ((n_we - we0) != MAXB) begin
            bad++;
            $display("FAIL max_len_writes got=%0d want=%0d", n_we - we0, MAXB);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_invalid_len;
        test_abort;
        test_reset_midload;
        test_random;
        test_max_len;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader/controller for the byte-addressed instruction ROM of the pipelined core. It accepts a program image as a byte stream over a valid/ready handshake and writes it byte-by-byte into instruction memory starting at the reset vector. It holds the pipeline stalled while loading and reports completion, an 8-bit additive checksum and error conditions. It sits between the external programming interface and the instruction memory write port, upstream of fetch.

## Interface
- ADDRESS_WIDTH, 32, width of the memory address bus
- DATA_WIDTH, 8, width of one memory location (byte)
- BASE_ADDR, 32'hBFC00000, address written by the first loaded byte
- MAX_BYTES, 4096, capacity of the instruction memory in bytes
- LEN_WIDTH, 13, width of len; must hold MAX_BYTES
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a load; sampled only in IDLE
- len  in  LEN_WIDTH  image length in bytes; sampled with start
- abort  in  1  cancel an in-progress load
- in_valid  in  1  byte stream valid
- in_data  in  DATA_WIDTH  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory byte write enable
- mem_addr  out  ADDRESS_WIDTH  write address
- mem_wdata  out  DATA_WIDTH  write data
- cpu_stall  out  1  hold the pipeline (fetch and PC) while loading
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse: load completed
- err  out  1  one-cycle pulse: rejected start or abort
- checksum  out  8  modulo-256 sum of bytes accepted in the current/last load

## Operation
- States: IDLE, LOAD, DRAIN, DONE. All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE:
  - start=1 with len valid (nonzero, len<=MAX_BYTES, len[1:0]==0) -> LOAD. Capture len into the remaining count, set the address counter to BASE_ADDR, clear checksum.
  - start=1 with an invalid len -> stay in IDLE and pulse err next cycle.
  - start=0 -> stay in IDLE.
- LOAD:
  - in_ready=1 and cpu_stall=1.
  - A byte is accepted when in_valid and in_ready are both 1 and abort=0.
  - On acceptance:
    - next cycle drives mem_we=1, mem_addr=current address, mem_wdata=in_data;
    - address increments by 1;
    - remaining count decrements by 1;
    - checksum += in_data (8-bit wrap).
  - Acceptance of the last byte (remaining==1) -> DRAIN.
  - No acceptance -> mem_we=0 next cycle; addr/wdata hold their last values.
- DRAIN: in_ready=0, cpu_stall=1. The final write is on the mem_* outputs. Unconditional -> DONE.
- DONE: done=1, cpu_stall=0, in_ready=0. Unconditional -> IDLE.
- abort:
  - In LOAD, abort has priority: any byte offered that cycle is discarded (no write, no checksum update). State goes to IDLE and err pulses next cycle.
  - A write already on mem_* (from the previous cycle's acceptance) still completes.
  - abort in IDLE, DRAIN or DONE is ignored.
- start outside IDLE is ignored.
- The address never exceeds BASE_ADDR+MAX_BYTES-1, because len is validated.
- checksum holds its value in IDLE until the next valid start.

## Timing
- Reset: state IDLE. in_ready, mem_we, cpu_stall, busy, done, err = 0. mem_addr=BASE_ADDR, mem_wdata=0, checksum=0.
- Reset mid-load returns to IDLE on the next edge with the reset values above. No done or err pulse is produced, and no further writes occur.
- Valid start sampled at edge N -> LOAD at N+1 (in_ready=1, cpu_stall=1, busy=1).
- Byte accepted at edge k -> write visible on mem_* during cycle k+1 (1-cycle latency).
- Last byte accepted at edge k:
  - DRAIN in cycle k+1 (final mem_we=1);
  - DONE in cycle k+2 (done=1, cpu_stall=0);
  - IDLE in cycle k+3.
- Minimum load time with in_valid held high: len+3 cycles from start to IDLE.
- Bad start at edge N -> err=1 during cycle N+1 only.
- abort at edge N -> IDLE and err=1 during cycle N+1.

## Test plan
- Reset then idle: rst held 2 cycles, then released -> all outputs 0 and mem_addr=32'hBFC00000. No writes over 10 idle cycles.
- Basic load: start with len=8 and bytes 01..08 streamed with in_valid=1:
  - writes go to BFC00000..BFC00007, each 1 cycle after acceptance;
  - done pulses exactly once, 2 cycles after the 8th byte;
  - checksum=8'h24; cpu_stall is high from start+1 through DRAIN.
- Backpressure gaps: len=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at consecutive addresses, mem_we=0 in gap cycles, done after the 4th byte.
- Invalid len: start with len=0, len=6 and len=4100 in turn -> each gives a 1-cycle err pulse, state stays IDLE, no writes, checksum unchanged.
- Abort: len=16, abort asserted together with in_valid on the 5th byte -> 4 writes only (the 5th is discarded), err pulses, cpu_stall drops next cycle, no done.
- Reset mid-load: rst asserted after 3 of 8 bytes -> outputs at reset values next cycle. A following start with len=4 loads from BFC00000 again with checksum restarted from 0.
